gba_sound_dsfifo: RTL and testbench

- Direct Sound FIFO (A or B): the consumer end of the timer overflow `tick` interface.
- CPU/DMA writes 32-bit sample words over the GBA register bus.
- Each tick from the selected timer (0 or 1) pops one signed 8-bit PCM sample to the mixer.
- Requests a DMA refill when the fill level drops to half or below.
- Two instances are built: FIFO A at 0x0A0 and FIFO B at 0x0A4.

---
 rtl/gba_sound_dsfifo_if.sv | 19 +
 rtl/gba_sound_dsfifo.sv | 99 +++++++++
 tb/tb_gba_sound_dsfifo.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/gba_sound_dsfifo_if.sv
// Register-bus bundle between the CPU/DMA side and a Direct Sound FIFO.
interface gba_sound_dsfifo_if;
    logic [31:0] gb_bus_din;
    logic [31:0] gb_bus_dout;
    logic [27:0] gb_bus_adr;
    logic        gb_bus_rnw;
    logic        gb_bus_ena;
    logic [3:0]  gb_bus_be;

    modport master (
        output gb_bus_din, gb_bus_adr, gb_bus_rnw, gb_bus_ena, gb_bus_be,
        input  gb_bus_dout
    );

    modport slave (
        input  gb_bus_din, gb_bus_adr, gb_bus_rnw, gb_bus_ena, gb_bus_be,
        output gb_bus_dout
    );
endinterface

// File: rtl/gba_sound_dsfifo.sv
// Direct Sound sample FIFO: bus byte-lane pushes, timer-tick pops to the mixer,
// and a refill request when the fill level drops to the half mark.
module gba_sound_dsfifo #(
    parameter logic [11:0] FIFO_ADR    = 12'h0A0,
    parameter int unsigned DEPTH_BYTES = 32,
    parameter int unsigned HALF_BYTES  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                gb_on,
    gba_sound_dsfifo_if.slave   bus,
    input  logic                timer_sel,
    input  logic                fifo_reset,
    input  logic                timer0_tick,
    input  logic                timer1_tick,
    output logic [7:0]          sample,
    output logic                sample_valid,
    output logic                dma_req,
    output logic [5:0]          fill_bytes,
    output logic                underflow,
    output logic                overflow
);
    localparam int unsigned PTR_W = $clog2(DEPTH_BYTES);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned LANES = 4;

    logic [7:0]       mem [DEPTH_BYTES];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic             pop_tick_c;
    logic             pop_c;
    logic             push_en_c;
    logic [CNT_W-1:0] free_c;
    logic [CNT_W-1:0] kept_c;
    logic [LANES-1:0] lane_wr_c;
    logic [PTR_W-1:0] lane_idx_c [LANES];
    logic             drop_c;
    logic             dma_c;

    assign bus.gb_bus_dout = 'z;
    assign fill_bytes      = 6'(count);

    // Lanes are packed in ascending order; lanes beyond the free space are dropped.
    // A pop in the same cycle frees one slot for the push.
    always_comb begin
        pop_tick_c = gb_on & (timer_sel ? timer1_tick : timer0_tick);
        pop_c      = pop_tick_c & (count != '0);
        push_en_c  = gb_on & bus.gb_bus_ena & ~bus.gb_bus_rnw
                     & (bus.gb_bus_adr == 28'(FIFO_ADR));
        free_c     = CNT_W'(DEPTH_BYTES) - count + CNT_W'(pop_c);
        kept_c     = '0;
        lane_wr_c  = '0;
        drop_c     = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            lane_idx_c[i] = wr_ptr + PTR_W'(kept_c);
            if (push_en_c && bus.gb_bus_be[i]) begin
                if (kept_c < free_c) begin
                    lane_wr_c[i] = 1'b1;
                    kept_c       = kept_c + CNT_W'(1);
                end else begin
                    drop_c = 1'b1;
                end
            end
        end
        dma_c = pop_tick_c & ((count - CNT_W'(pop_c)) <= CNT_W'(HALF_BYTES));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (lane_wr_c[i]) mem[lane_idx_c[i]] <= bus.gb_bus_din[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        sample_valid <= 1'b0;
        dma_req      <= 1'b0;
        underflow    <= 1'b0;
        overflow     <= 1'b0;
        if (reset || fifo_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            sample <= '0;
        end else begin
            if (pop_c) begin
                sample       <= mem[rd_ptr];
                rd_ptr       <= rd_ptr + PTR_W'(1);
                sample_valid <= 1'b1;
            end
            underflow <= pop_tick_c & ~pop_c;
            dma_req   <= dma_c;
            overflow  <= drop_c;
            wr_ptr    <= wr_ptr + PTR_W'(kept_c);
            count     <= count + kept_c - CNT_W'(pop_c);
        end
    end
endmodule

// File: tb/tb_gba_sound_dsfifo.sv
// Self-checking bench for gba_sound_dsfifo against a byte-queue reference model.
module tb_gba_sound_dsfifo;
    logic       clk = 1'b0;
    logic       reset, gb_on, timer_sel, fifo_reset, t0, t1;
    logic [7:0] sample;
    logic       sample_valid, dma_req, underflow, overflow;
    logic [5:0] fill_bytes;

    gba_sound_dsfifo_if bus ();

    gba_sound_dsfifo dut (
        .clk(clk), .reset(reset), .gb_on(gb_on), .bus(bus.slave),
        .timer_sel(timer_sel), .fifo_reset(fifo_reset),
        .timer0_tick(t0), .timer1_tick(t1),
        .sample(sample), .sample_valid(sample_valid), .dma_req(dma_req),
        .fill_bytes(fill_bytes), .underflow(underflow), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    byte unsigned q[$];
    logic [7:0]   m_sample;
    logic         m_sv, m_dr, m_uf, m_ov;

    typedef struct {
        logic        ena;
        logic [3:0]  be;
        logic [31:0] din;
        logic        tick;
        logic [7:0]  exp_sample;
        logic        exp_sv;
        logic        exp_dr;
        logic [5:0]  exp_fill;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the FIFO is a byte queue; pops use the pre-cycle level.
    task automatic model_step();
        m_sv = 0; m_dr = 0; m_uf = 0; m_ov = 0;
        if (reset || fifo_reset) begin
            q.delete();
            m_sample = 8'h00;
        end else if (gb_on) begin
            if (timer_sel ? t1 : t0) begin
                if (q.size() > 0) begin
                    m_sample = q.pop_front();
                    m_sv = 1;
                end else begin
                    m_uf = 1;
                end
                m_dr = (q.size() <= 16);
            end
            if (bus.gb_bus_ena && !bus.gb_bus_rnw && bus.gb_bus_adr == 28'h0A0) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.gb_bus_be[i]) begin
                        if (q.size() < 32) q.push_back(bus.gb_bus_din[8*i +: 8]);
                        else m_ov = 1;
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("sample", 32'(sample), 32'(m_sample));
        chk("sample_valid", 32'(sample_valid), 32'(m_sv));
        chk("dma_req", 32'(dma_req), 32'(m_dr));
        chk("underflow", 32'(underflow), 32'(m_uf));
        chk("overflow", 32'(overflow), 32'(m_ov));
        chk("fill_bytes", 32'(fill_bytes), 32'(q.size()));
        reset = 0; fifo_reset = 0; t0 = 0; t1 = 0; bus.gb_bus_ena = 0;
    endtask

    task automatic set_write(input logic [31:0] d, input logic [3:0] be);
        bus.gb_bus_ena = 1; bus.gb_bus_rnw = 0; bus.gb_bus_adr = 28'h0A0;
        bus.gb_bus_din = d; bus.gb_bus_be = be;
    endtask

    task automatic do_reset();
        reset = 1;
        cycle();
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && q.size() > 0; k++) begin
            t0 = 1;
            cycle();
        end
    endtask

    initial begin
        reset = 1; gb_on = 1; timer_sel = 0; fifo_reset = 0; t0 = 0; t1 = 0;
        bus.gb_bus_ena = 0; bus.gb_bus_rnw = 0; bus.gb_bus_adr = 28'h0A0;
        bus.gb_bus_din = '0; bus.gb_bus_be = '0;
        m_sample = 0;
        #1;
        do_reset();

        // Word write then four timer0 ticks.
        tbl[0] = '{1'b1, 4'hF, 32'h04030201, 1'b0, 8'h00, 1'b0, 1'b0, 6'd4};
        tbl[1] = '{1'b0, 4'h0, 32'h0,        1'b1, 8'h01, 1'b1, 1'b1, 6'd3};
        tbl[2] = '{1'b0, 4'h0, 32'h0,        1'b1, 8'h02, 1'b1, 1'b1, 6'd2};
        tbl[3] = '{1'b0, 4'h0, 32'h0,        1'b1, 8'h03, 1'b1, 1'b1, 6'd1};
        tbl[4] = '{1'b0, 4'h0, 32'h0,        1'b1, 8'h04, 1'b1, 1'b1, 6'd0};
        for (int v = 0; v < 5; v++) begin
            if (tbl[v].ena) set_write(tbl[v].din, tbl[v].be);
            t0 = tbl[v].tick;
            cycle();
            chk("tbl_sample", 32'(sample), 32'(tbl[v].exp_sample));
            chk("tbl_valid", 32'(sample_valid), 32'(tbl[v].exp_sv));
            chk("tbl_dma", 32'(dma_req), 32'(tbl[v].exp_dr));
            chk("tbl_fill", 32'(fill_bytes), 32'(tbl[v].exp_fill));
        end

        // Fill to 32, overflow on the ninth word, dma_req first on the 16th tick.
        for (int w = 0; w < 8; w++) begin
            set_write($urandom, 4'hF);
            cycle();
        end
        set_write(32'hDEADBEEF, 4'hF);
        cycle();
        chk("full_overflow", 32'(overflow), 32'd1);
        chk("full_fill", 32'(fill_bytes), 32'd32);
        for (int k = 1; k <= 16; k++) begin
            t0 = 1;
            cycle();
            chk("dma_half", 32'(dma_req), 32'(k == 16));
        end

        // Underflow leaves sample alone; partial-lane write.
        drain();
        t0 = 1;
        cycle();
        chk("empty_underflow", 32'(underflow), 32'd1);
        set_write(32'h0000BBAA, 4'b0011);
        cycle();
        chk("half_write_fill", 32'(fill_bytes), 32'd2);
        t0 = 1; cycle();
        chk("lane0_first", 32'(sample), 32'hAA);
        t0 = 1; cycle();
        chk("lane1_second", 32'(sample), 32'hBB);

        // Timer select routes only timer1.
        set_write(32'h44332211, 4'hF);
        cycle();
        timer_sel = 1;
        t0 = 1; cycle();
        chk("sel_ignores_t0", 32'(sample_valid), 32'd0);
        t1 = 1; cycle();
        chk("sel_uses_t1", 32'(sample), 32'h11);
        timer_sel = 0;

        // Same-cycle push and tick at empty and at 30.
        do_reset();
        set_write(32'h0D0C0B0A, 4'hF); t0 = 1;
        cycle();
        chk("same_empty_fill", 32'(fill_bytes), 32'd4);
        do_reset();
        for (int w = 0; w < 7; w++) begin set_write($urandom, 4'hF); cycle(); end
        set_write(32'h0000BEEF, 4'b0011); cycle();
        set_write(32'hCAFEF00D, 4'hF); t0 = 1;
        cycle();
        chk("same30_overflow", 32'(overflow), 32'd1);
        chk("same30_fill", 32'(fill_bytes), 32'd32);

        // fifo_reset beats push and tick; gb_on low freezes.
        do_reset();
        for (int w = 0; w < 5; w++) begin set_write($urandom, 4'hF); cycle(); end
        t0 = 1; cycle();
        set_write(32'h12345678, 4'hF); t0 = 1; fifo_reset = 1;
        cycle();
        chk("flush_fill", 32'(fill_bytes), 32'd0);
        chk("flush_sample", 32'(sample), 32'd0);
        set_write(32'h87654321, 4'hF); cycle();
        gb_on = 0;
        t0 = 1; set_write(32'h11111111, 4'hF);
        cycle();
        chk("off_fill", 32'(fill_bytes), 32'd4);
        gb_on = 1;

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 499) == 0);
            fifo_reset = ($urandom_range(0, 199) == 0);
            gb_on      = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 63) == 0) timer_sel = ~timer_sel;
            t0 = ($urandom_range(0, 9) < 3);
            t1 = ($urandom_range(0, 9) < 3);
            bus.gb_bus_ena = ($urandom_range(0, 9) < 3);
            bus.gb_bus_rnw = ($urandom_range(0, 9) == 0);
            bus.gb_bus_adr = ($urandom_range(0, 6) == 0) ? 28'h0A4 : 28'h0A0;
            bus.gb_bus_din = $urandom;
            bus.gb_bus_be  = 4'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
